// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: bridges pipeline MEM-stage loads/stores onto a word bus with lane steering, sign extension and timeout.
// Ports:
//   clk, rst (sync, active low)
//   MEM side : req_valid/req_write/req_addr/req_wdata/req_size/req_unsigned in; req_ready, stall out
//   response : resp_valid, resp_rdata, resp_err out
//   bus side : bus_valid/bus_write/bus_addr/bus_wdata/bus_wstrb out; bus_ready, bus_rvalid, bus_rdata in
module mem_bus_bridge #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            req_ready,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            bus_valid,
  output logic            bus_write,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_ready,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata, w_wdata, w_shift, w_ext;
  logic [1:0]      r_size;
  logic [3:0]      r_wstrb, w_wstrb;
  logic [7:0]      r_cnt;
  logic            r_write, r_unsigned, r_err;
  logic            w_bad, w_hs, w_tmo, w_expire;
  always_comb begin
    w_hs    = r_state == IDLE && req_valid;
    w_bad   = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    w_wstrb = !req_write ? 4'b0000 :
              req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
              req_size == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) :
              req_size == 2'd2 ? 4'b1111 : 4'b0000;
    w_wdata = req_size == 2'd0 ? {(XLEN/8){req_wdata[7:0]}} :
              req_size == 2'd1 ? {(XLEN/16){req_wdata[15:0]}} : req_wdata;
    // Only aligned accesses reach RDATA, so a byte-granular shift also serves halves and words.
    w_shift = bus_rdata >> {r_addr[1:0], 3'b000};
    w_ext   = r_size == 2'd0 ? {{(XLEN-8){~r_unsigned & w_shift[7]}}, w_shift[7:0]} :
              r_size == 2'd1 ? {{(XLEN-16){~r_unsigned & w_shift[15]}}, w_shift[15:0]} : bus_rdata;
    // >= rather than == so a load that reaches RDATA on the last count still times out.
    w_tmo    = r_cnt >= 8'(TIMEOUT - 1);
    // Timeout only fires when the current phase is not completing this cycle.
    w_expire = w_tmo && ((r_state == REQ && !bus_ready) || (r_state == RDATA && !bus_rvalid));
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? (w_bad ? RESP : REQ) : IDLE;
      REQ:     w_next = bus_ready ? (r_write ? RESP : RDATA) : (w_expire ? RESP : REQ);
      RDATA:   w_next = (bus_rvalid || w_expire) ? RESP : RDATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_size     <= '0;
      r_wstrb    <= '0;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_addr     <= req_addr;
        r_wdata    <= w_wdata;
        r_size     <= req_size;
        r_wstrb    <= w_wstrb;
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_err      <= w_bad;
        r_rdata    <= '0;
        r_cnt      <= '0;
      end
      if (r_state == REQ || r_state == RDATA) r_cnt <= r_cnt + 8'd1;
      if (r_state == RDATA && bus_rvalid) r_rdata <= w_ext;
      if (w_expire) r_err <= 1'b1;
    end
  end
  assign req_ready  = r_state == IDLE;
  assign stall      = r_state != IDLE || req_valid;
  assign resp_valid = r_state == RESP;
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign bus_valid  = r_state == REQ;
  assign bus_write  = r_write;
  assign bus_addr   = {r_addr[XLEN-1:2], 2'b00};
  assign bus_wdata  = r_wdata;
  assign bus_wstrb  = r_wstrb;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed self-checking bench for mem_bus_bridge.
module tb_mem_bus_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_valid, bus_write;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_rvalid;
  int          n_vec = 0;
  int          n_bad = 0;
  mem_bus_bridge #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic uns);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = uns;
    #1;
    chk("hs_stall", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_write", {31'd0, bus_write}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    req_valid = 1'b1; #1;
    chk("rst_stall_valid", {31'd0, stall}, 32'd1);
    req_valid = 1'b0; rst = 1'b1;
    tick();
    // byte store
    bus_ready = 1'b1;
    issue(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 1'b0);
    chk("bst_bus_valid", {31'd0, bus_valid}, 32'd1);
    chk("bst_bus_write", {31'd0, bus_write}, 32'd1);
    chk("bst_bus_addr", bus_addr, 32'h0000_1000);
    chk("bst_wstrb", {28'd0, bus_wstrb}, 32'h8);
    chk("bst_wdata", bus_wdata, 32'hA5A5_A5A5);
    chk("bst_resp_early", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("bst_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("bst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("bst_bus_valid_off", {31'd0, bus_valid}, 32'd0);
    chk("bst_ready_resp", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bst_resp_pulse", {31'd0, resp_valid}, 32'd0);
    chk("bst_ready_idle", {31'd0, req_ready}, 32'd1);
    // signed half load
    issue(1'b0, 32'h0000_2002, 32'h0, 2'd1, 1'b0);
    chk("hld_bus_valid", {31'd0, bus_valid}, 32'd1);
    chk("hld_wstrb", {28'd0, bus_wstrb}, 32'h0);
    chk("hld_bus_addr", bus_addr, 32'h0000_2000);
    tick();
    chk("hld_rdata_state", {31'd0, bus_valid}, 32'd0);
    chk("hld_not_yet", {31'd0, resp_valid}, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h8001_7FFF;
    tick();
    bus_rvalid = 1'b0;
    chk("hld_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hld_rdata_s", resp_rdata, 32'hFFFF_8001);
    chk("hld_err", {31'd0, resp_err}, 32'd0);
    tick();
    // unsigned half load
    issue(1'b0, 32'h0000_2002, 32'h0, 2'd1, 1'b1);
    tick();
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    chk("hldu_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hldu_rdata", resp_rdata, 32'h0000_8001);
    tick();
    // signed byte load from lane 1
    issue(1'b0, 32'h0000_0001, 32'h0, 2'd0, 1'b0);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_8000;
    tick();
    bus_rvalid = 1'b0;
    chk("bld_rdata", resp_rdata, 32'hFFFF_FF80);
    tick();
    // misaligned word load
    issue(1'b0, 32'h0000_0006, 32'h0, 2'd2, 1'b0);
    chk("mis_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_err", {31'd0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    tick();
    // illegal size
    issue(1'b1, 32'h0000_0000, 32'h55, 2'd3, 1'b0);
    chk("ill_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("ill_err", {31'd0, resp_err}, 32'd1);
    tick();
    chk("ill_back_idle", {31'd0, req_ready}, 32'd1);
    // backpressure on a half store
    bus_ready = 1'b0;
    issue(1'b1, 32'h0000_3002, 32'h0000_1234, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_bus_valid", {31'd0, bus_valid}, 32'd1);
      chk("bp_bus_addr", bus_addr, 32'h0000_3000);
      chk("bp_wstrb", {28'd0, bus_wstrb}, 32'hC);
      chk("bp_wdata", bus_wdata, 32'h1234_1234);
      chk("bp_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    bus_ready = 1'b1;
    tick();
    chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("bp_err", {31'd0, resp_err}, 32'd0);
    tick();
    // timeout in RDATA
    issue(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1'b0);
    tick();
    bus_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("to_wait", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    chk("to_wait_last", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("to_err", {31'd0, resp_err}, 32'd1);
    chk("to_rdata", resp_rdata, 32'd0);
    tick();
    bus_ready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'h0000_0077, 2'd0, 1'b0);
    chk("to_next_wstrb", {28'd0, bus_wstrb}, 32'h1);
    tick();
    chk("to_next_resp", {31'd0, resp_valid}, 32'd1);
    chk("to_next_err", {31'd0, resp_err}, 32'd0);
    tick();
    // completion coincides with timeout
    issue(1'b0, 32'h0000_0044, 32'h0, 2'd2, 1'b0);
    tick();
    bus_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("cw_still_wait", {31'd0, resp_valid}, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    bus_rvalid = 1'b0;
    chk("cw_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("cw_err", {31'd0, resp_err}, 32'd0);
    chk("cw_rdata", resp_rdata, 32'h1122_3344);
    tick();
    // reset during RDATA
    bus_ready = 1'b1;
    issue(1'b0, 32'h0000_0050, 32'h0, 2'd2, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rr_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rr_ready", {31'd0, req_ready}, 32'd1);
    tick();
    bus_rvalid = 1'b0;
    chk("rr_resp_valid2", {31'd0, resp_valid}, 32'd0);
    chk("rr_ready2", {31'd0, req_ready}, 32'd1);
    chk("rr_bus_valid", {31'd0, bus_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
